// File: rtl/alu_exec_if.sv
// Request/response bundle between the decode stage (master) and the ALU execute stage (slave).
// A transfer happens on a rising edge where valid and ready are both high; valid-side payload is held until then.
interface alu_exec_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       alu_cmd;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             shiftcarry_in;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rslt;
  logic             shiftcarry_out;
  logic             zero;
  logic             rsp_err;

  modport master (
    output req_valid, alu_cmd, inA, inB, shiftcarry_in, rsp_ready,
    input  req_ready, rsp_valid, rslt, shiftcarry_out, zero, rsp_err
  );

  modport slave (
    input  req_valid, alu_cmd, inA, inB, shiftcarry_in, rsp_ready,
    output req_ready, rsp_valid, rslt, shiftcarry_out, zero, rsp_err
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered, handshaked execute stage for the 8-bit ALU command set.
// Shifts take one cycle per bit; every other command resolves in a single cycle.
module alu_exec_stage #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  alu_exec_if.slave  bus,
  output logic [1:0] state_dbg
);

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_XOR = 4'b0001;
  localparam logic [3:0] CMD_OR  = 4'b0010;
  localparam logic [3:0] CMD_LSL = 4'b0011;
  localparam logic [3:0] CMD_LSR = 4'b0100;
  localparam logic [3:0] CMD_ADD = 4'b0101;
  localparam logic [3:0] CMD_SUB = 4'b0110;
  localparam logic [3:0] CMD_PSA = 4'b0111;

  // RESOLVE is the single cycle that publishes the working result onto the output registers.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   work_r;
  logic               work_c;
  logic               work_err;
  logic               fill;
  logic               shift_left;
  logic [SHAMT_W-1:0] cnt;

  logic [WIDTH-1:0]   acc_r;
  logic               acc_c;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;

  assign state_dbg = state;
  assign shamt     = bus.inB[SHAMT_W-1:0];
  assign is_shift  = (bus.alu_cmd == CMD_LSL) || (bus.alu_cmd == CMD_LSR);

  // Single-cycle result from the live request; a shift lands here only when its amount is zero.
  always_comb begin
    acc_r = '0;
    acc_c = 1'b0;
    case (bus.alu_cmd)
      CMD_AND: acc_r = bus.inA & bus.inB;
      CMD_XOR: acc_r = bus.inA ^ bus.inB;
      CMD_OR:  acc_r = bus.inA | bus.inB;
      CMD_PSA: acc_r = bus.inA;
      CMD_ADD: {acc_c, acc_r} = {1'b0, bus.inA} + {1'b0, bus.inB};
      CMD_SUB: begin
        acc_r = bus.inA - bus.inB;
        acc_c = (bus.inA >= bus.inB);
      end
      CMD_LSL, CMD_LSR: begin
        acc_r = bus.inA;
        acc_c = bus.shiftcarry_in;
      end
      default: begin
        acc_r = '0;
        acc_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      bus.req_ready      <= 1'b1;
      bus.rsp_valid      <= 1'b0;
      bus.rslt           <= '0;
      bus.shiftcarry_out <= 1'b0;
      bus.zero           <= 1'b0;
      bus.rsp_err        <= 1'b0;
      work_r             <= '0;
      work_c             <= 1'b0;
      work_err           <= 1'b0;
      fill               <= 1'b0;
      shift_left         <= 1'b0;
      cnt                <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            fill          <= bus.shiftcarry_in;
            shift_left    <= (bus.alu_cmd == CMD_LSL);
            work_err      <= bus.alu_cmd[3];
            if (is_shift && (shamt != '0)) begin
              work_r <= bus.inA;
              work_c <= 1'b0;
              cnt    <= shamt;
              state  <= SHIFT;
            end else begin
              work_r <= acc_r;
              work_c <= acc_c;
              state  <= RESOLVE;
            end
          end
        end
        SHIFT: begin
          if (shift_left) begin
            work_r <= {work_r[WIDTH-2:0], fill};
            work_c <= work_r[WIDTH-1];
          end else begin
            work_r <= {fill, work_r[WIDTH-1:1]};
            work_c <= work_r[0];
          end
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            state <= RESOLVE;
          end
        end
        RESOLVE: begin
          bus.rslt           <= work_r;
          bus.shiftcarry_out <= work_c;
          bus.zero           <= (work_r == '0);
          bus.rsp_err        <= work_err;
          bus.rsp_valid      <= 1'b1;
          state              <= DONE;
        end
        DONE: begin
          // req_ready stays low through the consuming edge, so back-to-back accept is impossible.
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized and directed bench for alu_exec_stage with a queue-based scoreboard.
// Expected results come from an arithmetic model of the command set.
module tb_alu_exec_stage;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;

  alu_exec_if #(.WIDTH(W)) bus();

  alu_exec_stage #(.WIDTH(W), .SHAMT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_q[$];
  int          lat_q[$];
  int          rdy_mode = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Result packed as {rsp_err, zero, shiftcarry_out, rslt}
  function automatic logic [10:0] model(input logic [3:0] cmd, input logic [7:0] a,
                                        input logic [7:0] b, input logic sci);
    int r;
    int c;
    int k;
    int ai;
    int bi;
    r  = 0;
    c  = 0;
    ai = int'(a);
    bi = int'(b);
    k  = bi % 8;
    if (cmd[3]) return {1'b1, 1'b1, 1'b0, 8'h00};
    case (cmd)
      4'd0: r = ai & bi;
      4'd1: r = ai ^ bi;
      4'd2: r = ai | bi;
      4'd7: r = ai;
      4'd5: begin
        r = (ai + bi) % 256;
        c = ((ai + bi) > 255) ? 1 : 0;
      end
      4'd6: begin
        r = (ai - bi + 256) % 256;
        c = (ai >= bi) ? 1 : 0;
      end
      4'd3: begin
        if (k == 0) begin
          r = ai;
          c = int'(sci);
        end else begin
          r = ((ai << k) | (sci ? ((1 << k) - 1) : 0)) % 256;
          c = (ai >> (8 - k)) & 1;
        end
      end
      default: begin
        if (k == 0) begin
          r = ai;
          c = int'(sci);
        end else begin
          r = (ai >> k) | (sci ? ((255 << (8 - k)) % 256) : 0);
          c = (ai >> (k - 1)) & 1;
        end
      end
    endcase
    return {1'b0, (r == 0), 1'(c), 8'(r)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                      input logic sci);
    int wait_n;
    int k;
    wait_n = 0;
    bus.alu_cmd       = cmd;
    bus.inA           = a;
    bus.inB           = b;
    bus.shiftcarry_in = sci;
    bus.req_valid     = 1'b1;
    while (!bus.req_ready && wait_n < 60) begin
      @(posedge clk); #1;
      wait_n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout actual=0 required=1 after %0d cycles", wait_n);
      bus.req_valid = 1'b0;
      return;
    end
    k = ((cmd == 4'd3) || (cmd == 4'd4)) ? int'(b[2:0]) : 0;
    exp_q.push_back(model(cmd, a, b, sci));
    lat_q.push_back(cyc + 2 + k);
    @(posedge clk); #1;
    bus.req_valid     = 1'b0;
    bus.alu_cmd       = 4'($urandom_range(0, 15));
    bus.inA           = 8'($urandom);
    bus.inB           = 8'($urandom);
    bus.shiftcarry_in = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
        1:       bus.rsp_ready = 1'b0;
        default: bus.rsp_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic was_valid = 1'b0;
  logic hs_pend   = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      was_valid = 1'b0;
      hs_pend   = 1'b0;
    end else begin
      if (hs_pend) begin
        check("post_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
        hs_pend = 1'b0;
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=%0h required=no_response",
                   {bus.rsp_err, bus.zero, bus.shiftcarry_out, bus.rslt});
        end else begin
          if (!was_valid && lat_q.size() != 0) begin
            check("latency", 32'(cyc), 32'(lat_q.pop_front()));
          end
          check("rsp", 32'({bus.rsp_err, bus.zero, bus.shiftcarry_out, bus.rslt}), 32'(exp_q[0]));
          check("req_ready_in_done", 32'(bus.req_ready), 32'd0);
          if (bus.rsp_ready) begin
            void'(exp_q.pop_front());
            hs_pend = 1'b1;
          end
        end
      end
      was_valid = bus.rsp_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] cmd;
    bus.req_valid     = 1'b0;
    bus.alu_cmd       = 4'd0;
    bus.inA           = 8'd0;
    bus.inB           = 8'd0;
    bus.shiftcarry_in = 1'b0;
    reset             = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rslt", 32'(bus.rslt), 32'd0);
    check("reset_cout", 32'(bus.shiftcarry_out), 32'd0);
    check("reset_zero", 32'(bus.zero), 32'd0);
    check("reset_err", 32'(bus.rsp_err), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;

    rdy_mode = 2;
    send(4'b0000, 8'hAA, 8'h55, 1'b0);
    send(4'b0101, 8'hFF, 8'h01, 1'b0);
    send(4'b0101, 8'hAA, 8'h55, 1'b1);
    send(4'b0110, 8'h05, 8'h07, 1'b0);
    send(4'b0110, 8'h07, 8'h05, 1'b1);
    send(4'b0011, 8'hAA, 8'h03, 1'b1);
    send(4'b0100, 8'hAA, 8'h01, 1'b0);
    send(4'b0011, 8'h3C, 8'h08, 1'b1);
    send(4'b0100, 8'h81, 8'hF7, 1'b1);
    send(4'b0111, 8'h00, 8'h12, 1'b1);
    send(4'b1010, 8'h5A, 8'hC3, 1'b1);
    drain();

    // Backpressure: response must hold steady while the consumer stalls
    rdy_mode = 1;
    send(4'b0001, 8'hF0, 8'h3C, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rdy_mode = 2;
    drain();

    // Reset in the middle of a 7-step shift drops the request
    send(4'b0011, 8'($urandom), 8'h07, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(posedge clk); #1;
    check("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midreset_rslt", 32'(bus.rslt), 32'd0);
    check("midreset_req_ready", 32'(bus.req_ready), 32'd1);
    reset = 1'b0;
    repeat (12) begin @(posedge clk); #1; end

    rdy_mode = 0;
    repeat (150) begin
      if ($urandom_range(0, 7) == 0) cmd = 4'(8 + $urandom_range(0, 7));
      else cmd = 4'($urandom_range(0, 7));
      send(cmd, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rdy_mode = 2;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
